// File: rtl/axi_log_pkg.sv
// Shared constants, entry layout and FSM states for the AXI log drain.
// Optional feature macro: AXI_LOG_DRAIN_AUTOCLEAR_EN (see axi_log_drain).
package axi_log_pkg;

    localparam int LOG_ENTRY_BITW      = 96;
    localparam int LOG_ENTRY_BYTEW     = 12;
    localparam int LOG_WORDS_PER_ENTRY = 3;
    localparam int LOG_WORD_BITW       = 32;
    localparam int LOG_WORD_BYTEW      = 4;

    localparam int LOG_TS_OFS   = 0;
    localparam int LOG_ADDR_OFS = 32;
    localparam int LOG_LEN_OFS  = 64;
    localparam int LOG_ID_OFS   = 72;

    typedef logic [LOG_ENTRY_BITW-1:0] log_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_WAIT,
        S_VALID,
        S_DONE
    } drain_state_e;

endpackage

// File: rtl/axi_log_entry_asm.sv
// Assembles three 32-bit BRAM words into one 96-bit log entry register.
// Optional feature macro: none (AXI_LOG_DRAIN_AUTOCLEAR_EN lives in the top).
module axi_log_entry_asm
    import axi_log_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     capture,
    input  logic [1:0]               word_sel,
    input  logic                     hold,
    input  logic [LOG_WORD_BITW-1:0] word,
    output log_entry_t               entry
);

    log_entry_t entry_q;

    // len and id share word 2, so the id field rides along at LOG_LEN_OFS
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (capture && !hold) begin
            unique case (word_sel)
                2'd0: entry_q[LOG_TS_OFS   +: LOG_WORD_BITW] <= word;
                2'd1: entry_q[LOG_ADDR_OFS +: LOG_WORD_BITW] <= word;
                2'd2: entry_q[LOG_LEN_OFS  +: LOG_WORD_BITW] <= word;
                default: entry_q <= entry_q;
            endcase
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/axi_log_drain.sv
// Drains NumEntries log records from BRAM as a 96-bit valid/ready stream.
// Optional feature macro: AXI_LOG_DRAIN_AUTOCLEAR_EN (pulse Clear_SO on completion).
module axi_log_drain
    import axi_log_pkg::*;
#(
    parameter int NUM_LOG_ENTRIES = 16384,
    parameter int BRAM_ADDR_BITW  = 32,
    localparam int CNT_BITW       = $clog2(NUM_LOG_ENTRIES) + 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      Start_SI,
    input  logic [CNT_BITW-1:0]       NumEntries_DI,
    input  logic                      Abort_SI,
    output logic                      BramEn_SO,
    output logic [BRAM_ADDR_BITW-1:0] BramAddr_DO,
    input  logic [31:0]               BramRd_DI,
    output logic [LOG_ENTRY_BITW-1:0] Entry_DO,
    output logic                      EntryValid_SO,
    input  logic                      EntryReady_SI,
    output logic                      Busy_SO,
    output logic                      Done_SO,
    output logic                      Clear_SO
);

    localparam logic [CNT_BITW-1:0] MAX_CNT = CNT_BITW'(NUM_LOG_ENTRIES);

    drain_state_e              state_q, state_d;
    logic [CNT_BITW-1:0]       remain_q;
    logic [CNT_BITW-1:0]       num_sat;
    logic [BRAM_ADDR_BITW-1:0] addr_q;
    logic                      bram_en;
    logic                      handshake;
    logic                      capture;
    logic [1:0]                word_sel;
    logic                      hold;

    assign num_sat   = (NumEntries_DI > MAX_CNT) ? MAX_CNT : NumEntries_DI;
    assign handshake = (state_q == S_VALID) && EntryReady_SI;

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start_SI) begin
                    state_d = (NumEntries_DI == '0) ? S_DONE : S_RD0;
                end
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_WAIT;
            S_WAIT: state_d = S_VALID;
            S_VALID: begin
                if (EntryReady_SI) begin
                    state_d = (remain_q <= CNT_BITW'(1)) ? S_DONE : S_RD0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Abort_SI) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI || Abort_SI) begin
            remain_q <= '0;
        end else if (state_q == S_IDLE && Start_SI) begin
            remain_q <= num_sat;
        end else if (handshake) begin
            remain_q <= remain_q - CNT_BITW'(1);
        end
    end

    // byte address walks +4 per word read; it only resets between drains
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI || Abort_SI || state_q == S_IDLE) begin
            addr_q <= '0;
        end else if (bram_en) begin
            addr_q <= addr_q + BRAM_ADDR_BITW'(LOG_WORD_BYTEW);
        end
    end

    assign bram_en = (state_q == S_RD0) || (state_q == S_RD1) ||
                     (state_q == S_RD2);

    // read data lags the address by one cycle, so word k lands in state RD(k+1)
    always_comb begin
        capture  = 1'b0;
        word_sel = 2'd0;
        unique case (state_q)
            S_RD1:  begin capture = 1'b1; word_sel = 2'd0; end
            S_RD2:  begin capture = 1'b1; word_sel = 2'd1; end
            S_WAIT: begin capture = 1'b1; word_sel = 2'd2; end
            default: begin capture = 1'b0; word_sel = 2'd0; end
        endcase
    end

    assign hold = (state_q == S_VALID) && !EntryReady_SI;

    axi_log_entry_asm u_asm (
        .clk      (Clk_CI),
        .rst_n    (Rst_RBI),
        .capture  (capture),
        .word_sel (word_sel),
        .hold     (hold),
        .word     (BramRd_DI),
        .entry    (Entry_DO)
    );

    assign BramEn_SO     = bram_en;
    assign BramAddr_DO   = bram_en ? addr_q : '0;
    assign EntryValid_SO = (state_q == S_VALID);
    assign Busy_SO       = (state_q != S_IDLE);
    assign Done_SO       = (state_q == S_DONE);

`ifdef AXI_LOG_DRAIN_AUTOCLEAR_EN
    assign Clear_SO = (state_q == S_DONE);
`else
    assign Clear_SO = 1'b0;
`endif

endmodule

// File: tb/tb_axi_log_drain.sv
// Directed self-checking bench for axi_log_drain with a 1-cycle BRAM model.
// Clear expectations follow AXI_LOG_DRAIN_AUTOCLEAR_EN when it is defined.
module tb_axi_log_drain;

    localparam int N    = 1024;
    localparam int CW   = $clog2(N) + 1;
    localparam int AW   = 32;

`ifdef AXI_LOG_DRAIN_AUTOCLEAR_EN
    localparam logic CLR_EXP = 1'b1;
`else
    localparam logic CLR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num;
    logic          abort;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_rd = '0;
    logic [95:0]   entry;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic          clear;

    int total  = 0;
    int passed = 0;

    axi_log_drain #(
        .NUM_LOG_ENTRIES (N),
        .BRAM_ADDR_BITW  (AW)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RBI       (rst_n),
        .Start_SI      (start),
        .NumEntries_DI (num),
        .Abort_SI      (abort),
        .BramEn_SO     (bram_en),
        .BramAddr_DO   (bram_addr),
        .BramRd_DI     (bram_rd),
        .Entry_DO      (entry),
        .EntryValid_SO (valid),
        .EntryReady_SI (ready),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .Clear_SO      (clear)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h11111111;
            32'd4:   return 32'h80001000;
            32'd8:   return 32'h0000050F;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (bram_en) bram_rd <= bram_word(bram_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; num = '0; abort = 1'b0; ready = 1'b0;
        tick(); tick();
        total++;
        if ({busy, bram_en, valid, done, clear} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {busy, bram_en, valid, done, clear});
        else passed++;
        total++;
        if (entry !== 96'h0 || bram_addr !== 32'h0)
            $display("FAIL reset_data got entry=%h addr=%h want 0", entry, bram_addr);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_entries;
        logic [95:0] exp;
        ready = 1'b1;
        start = 1'b1; num = CW'(2);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (bram_en !== 1'b1 || bram_addr !== 32'(12*i + 4*k))
                    $display("FAIL rd_addr e%0d w%0d got en=%b addr=%0d want en=1 addr=%0d",
                             i, k, bram_en, bram_addr, 12*i + 4*k);
                else passed++;
                tick();
            end
            total++;
            if (bram_en !== 1'b0 || valid !== 1'b0)
                $display("FAIL wait_state e%0d got en=%b valid=%b want 0 0", i, bram_en, valid);
            else passed++;
            tick();
            exp = {bram_word(32'(12*i+8)), bram_word(32'(12*i+4)), bram_word(32'(12*i))};
            total++;
            if (valid !== 1'b1 || entry !== exp)
                $display("FAIL entry e%0d got valid=%b entry=%h want 1 %h", i, valid, entry, exp);
            else passed++;
            tick();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || clear !== CLR_EXP)
            $display("FAIL done_pulse got done=%b busy=%b clear=%b want 1 1 %b",
                     done, busy, clear, CLR_EXP);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || clear !== 1'b0)
            $display("FAIL back_idle got done=%b busy=%b clear=%b want 0 0 0", done, busy, clear);
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [95:0] held;
        int bad;
        ready = 1'b0;
        start = 1'b1; num = CW'(2);
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        total++;
        if (valid !== 1'b1 || entry !== 96'h0000050F_80001000_11111111)
            $display("FAIL bp_first got valid=%b entry=%h want 1 0000050f8000100011111111",
                     valid, entry);
        else passed++;
        held = 96'h0000050F_80001000_11111111;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            num = '0;
            tick();
            if (valid !== 1'b1 || bram_en !== 1'b0 || entry !== held) bad++;
        end
        start = 1'b0;
        total++;
        if (bad != 0)
            $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        else passed++;
        ready = 1'b1;
        tick();
        total++;
        if (bram_en !== 1'b1 || bram_addr !== 32'd12)
            $display("FAIL bp_resume got en=%b addr=%0d want 1 12", bram_en, bram_addr);
        else passed++;
        tick(); tick(); tick(); tick();
        total++;
        if (valid !== 1'b1 || entry !== {bram_word(32'd20), bram_word(32'd16), bram_word(32'd12)})
            $display("FAIL bp_second got valid=%b entry=%h", valid, entry);
        else passed++;
        tick();
        total++;
        if (done !== 1'b1)
            $display("FAIL bp_done got %b want 1", done);
        else passed++;
        tick();
    endtask

    task automatic test_zero;
        ready = 1'b1;
        start = 1'b1; num = '0;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || bram_en !== 1'b0 || clear !== CLR_EXP)
            $display("FAIL zero_done got done=%b en=%b clear=%b want 1 0 %b",
                     done, bram_en, clear, CLR_EXP);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || clear !== 1'b0)
            $display("FAIL zero_idle got done=%b busy=%b clear=%b want 0 0 0", done, busy, clear);
        else passed++;
    endtask

    task automatic test_abort;
        ready = 1'b1;
        start = 1'b1; num = CW'(3);
        tick();
        start = 1'b0;
        tick();
        total++;
        if (bram_addr !== 32'd4 || bram_en !== 1'b1)
            $display("FAIL abort_rd1 got en=%b addr=%0d want 1 4", bram_en, bram_addr);
        else passed++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, valid, done, clear, bram_en} !== 5'b0)
            $display("FAIL abort_rd1_idle got %b want 00000", {busy, valid, done, clear, bram_en});
        else passed++;
        start = 1'b1; num = CW'(2);
        tick();
        start = 1'b0;
        total++;
        if (bram_en !== 1'b1 || bram_addr !== 32'd0)
            $display("FAIL abort_restart got en=%b addr=%0d want 1 0", bram_en, bram_addr);
        else passed++;
        tick(); tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({busy, valid, done, clear} !== 4'b0)
            $display("FAIL abort_hs got %b want 0000", {busy, valid, done, clear});
        else passed++;
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_hs_after got done=%b busy=%b want 0 0", done, busy);
        else passed++;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; num = CW'(2);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({busy, done, clear, bram_en} !== 4'b0 || entry !== 96'h0)
            $display("FAIL reset_mid got ctrl=%b entry=%h want 0000 0",
                     {busy, done, clear, bram_en}, entry);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturate;
        int n_valid;
        int last_addr;
        int max_addr;
        bit seen_done;
        n_valid = 0; last_addr = -1; max_addr = 0; seen_done = 0;
        ready = 1'b1;
        start = 1'b1; num = CW'(N + 5);
        tick();
        start = 1'b0;
        for (int c = 0; c < 6000 && !seen_done; c++) begin
            if (bram_en) begin
                last_addr = int'(bram_addr);
                if (last_addr > max_addr) max_addr = last_addr;
            end
            if (valid) n_valid++;
            if (done) seen_done = 1;
            tick();
        end
        total++;
        if (!seen_done)
            $display("FAIL sat_timeout got no done want done");
        else passed++;
        total++;
        if (n_valid != N)
            $display("FAIL sat_count got %0d want %0d", n_valid, N);
        else passed++;
        total++;
        if (last_addr != 12*N - 4 || max_addr != 12*N - 4)
            $display("FAIL sat_addr got last=%0d max=%0d want %0d", last_addr, max_addr, 12*N - 4);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_two_entries();
        test_backpressure();
        test_zero();
        test_abort();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
